// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, RAM handshake state and arbiter states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache.
// dcache has priority and holds the port across a two-word block; a starve
// counter forces an icache grant once too many dcache words went by while
// the icache was waiting.
import cpu_types_pkg::*;

module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    // icache side
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    // dcache side
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    // RAM port
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] starve;
    logic [CNT_W-1:0] starve_next;
    ramstate_t        rs;
    logic             done;
    logic             dreq;

    assign rs   = ramstate_t'(ramstate);
    assign done = (rs == ACCESS);
    assign dreq = dREN | dWEN;

    // Read data is shared by both caches; each only uses it when its wait drops.
    assign iload = ramload;
    assign dload = ramload;

    // State and starve counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= state_next;
            starve <= starve_next;
        end
    end

    // Next-state and RAM/cache handshake decode.
    always_comb begin
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        case (state)
            IDLE: begin
                if (iREN && (starve >= STARVE_LIM)) begin
                    state_next = ISERV;
                end else if (dreq) begin
                    state_next = DSERV;
                end else if (iREN) begin
                    state_next = ISERV;
                end
            end
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~done;
                // Even word keeps the lock so the odd word of the block follows.
                if (!dreq) begin
                    state_next = IDLE;
                end else if (done && daddr[2]) begin
                    state_next = IDLE;
                end
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = ~done;
                if (done || !iREN) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Hold every output at its idle value while reset is asserted.
        if (!nRST) begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
            iwait    = 1'b1;
            dwait    = 1'b1;
        end
    end

    // Starve counter: counts dcache words served while the icache waits.
    always_comb begin
        starve_next = starve;
        if (!iREN) begin
            starve_next = '0;
        end else if ((state == ISERV) && done) begin
            starve_next = '0;
        end else if ((state == DSERV) && done && (starve < STARVE_LIM)) begin
            starve_next = starve + CNT_W'(1);
        end
    end

endmodule
